// File: rtl/win_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module     : win_checker
// Description: Four-in-a-row win detector for a 6x7 board. After a piece is
//              placed, walks outward from it in four directions, one probe per
//              cycle, through an external combinational cell-state port.
// Revision   : 1.0 - initial release
// ============================================================================
module win_checker (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] last_row,
    input  logic [2:0] last_col,
    input  logic       player,
    output logic [2:0] probe_row,
    output logic [2:0] probe_col,
    input  logic       cell_empty,
    input  logic       cell_p1,
    input  logic       cell_p2,
    output logic       busy,
    output logic       done,
    output logic       win,
    output logic [1:0] win_dir
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic signed [4:0] c_row_max = 5'sd5;
    localparam logic signed [4:0] c_col_max = 5'sd6;

    state_t      state_q,   state_d;
    logic [2:0]  row_q,     row_d;
    logic [2:0]  col_q,     col_d;
    logic        player_q,  player_d;
    logic [1:0]  dir_q,     dir_d;
    logic        side_q,    side_d;     // 0 = walking +delta, 1 = walking -delta
    logic [1:0]  step_q,    step_d;
    logic [2:0]  count_q,   count_d;
    logic        win_q,     win_d;
    logic [1:0]  win_dir_q, win_dir_d;
    logic        done_q,    done_d;
    logic        busy_q,    busy_d;

    logic signed [4:0] w_off;
    logic signed [4:0] w_dr;
    logic signed [4:0] w_dc;
    logic signed [4:0] w_cand_r;
    logic signed [4:0] w_cand_c;
    logic              w_in_bounds;
    logic              w_match;
    logic              w_hit;
    logic              w_side_end;

    // The empty flag is implied by the absence of both player flags.
    logic unused_cell_empty;
    assign unused_cell_empty = cell_empty;

    // Candidate cell = placed cell + signed step along the current direction.
    always_comb begin
        w_off = side_q ? -$signed({3'b000, step_q}) : $signed({3'b000, step_q});
        w_dr  = 5'sd0;
        w_dc  = 5'sd0;
        case (dir_q)
            2'd0:    begin w_dr = 5'sd0; w_dc = w_off;  end
            2'd1:    begin w_dr = w_off; w_dc = 5'sd0;  end
            2'd2:    begin w_dr = w_off; w_dc = w_off;  end
            default: begin w_dr = w_off; w_dc = -w_off; end
        endcase
        w_cand_r    = $signed({2'b00, row_q}) + w_dr;
        w_cand_c    = $signed({2'b00, col_q}) + w_dc;
        w_in_bounds = (w_cand_r >= 5'sd0) && (w_cand_r <= c_row_max) &&
                      (w_cand_c >= 5'sd0) && (w_cand_c <= c_col_max);
        w_match     = player_q ? cell_p2 : cell_p1;
        w_hit       = (state_q == SCAN) && w_in_bounds && w_match;
        probe_row   = ((state_q == SCAN) && w_in_bounds) ? w_cand_r[2:0] : 3'd0;
        probe_col   = ((state_q == SCAN) && w_in_bounds) ? w_cand_c[2:0] : 3'd0;
    end

    // Next-state logic: accept a move, walk one cell or end one side per cycle.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        player_d   = player_q;
        dir_d      = dir_q;
        side_d     = side_q;
        step_d     = step_q;
        count_d    = count_q;
        win_d      = win_q;
        win_dir_d  = win_dir_q;
        done_d     = 1'b0;
        busy_d     = busy_q;
        w_side_end = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    win_d     = 1'b0;
                    win_dir_d = 2'd0;
                    if ((last_row > 3'd5) || (last_col > 3'd6)) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        row_d    = last_row;
                        col_d    = last_col;
                        player_d = player;
                        dir_d    = 2'd0;
                        side_d   = 1'b0;
                        step_d   = 2'd1;
                        count_d  = 3'd1;
                        state_d  = SCAN;
                        busy_d   = 1'b1;
                    end
                end
            end

            SCAN: begin
                if (w_hit) begin
                    count_d = count_q + 3'd1;
                    if (count_q == 3'd3) begin
                        state_d   = FIN;
                        win_d     = 1'b1;
                        win_dir_d = dir_q;
                        done_d    = 1'b1;
                        busy_d    = 1'b0;
                    end else if (step_q == 2'd3) begin
                        w_side_end = 1'b1;
                    end else begin
                        step_d = step_q + 2'd1;
                    end
                end else begin
                    w_side_end = 1'b1;
                end

                if (w_side_end) begin
                    step_d = 2'd1;
                    if (!side_q) begin
                        side_d = 1'b1;
                    end else begin
                        side_d  = 1'b0;
                        count_d = 3'd1;
                        if (dir_q == 2'd3) begin
                            state_d = FIN;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end else begin
                            dir_d = dir_q + 2'd1;
                        end
                    end
                end
            end

            FIN: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset clears everything immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            row_q     <= 3'd0;
            col_q     <= 3'd0;
            player_q  <= 1'b0;
            dir_q     <= 2'd0;
            side_q    <= 1'b0;
            step_q    <= 2'd0;
            count_q   <= 3'd0;
            win_q     <= 1'b0;
            win_dir_q <= 2'd0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            player_q  <= player_d;
            dir_q     <= dir_d;
            side_q    <= side_d;
            step_q    <= step_d;
            count_q   <= count_d;
            win_q     <= win_d;
            win_dir_q <= win_dir_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign win     = win_q;
    assign win_dir = win_dir_q;

endmodule
`default_nettype wire

// File: tb/tb_win_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module     : tb_win_checker
// Description: Directed scoreboard bench for win_checker with a board model
//              answering the probe port.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_win_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] last_row;
    logic [2:0] last_col;
    logic       player;
    logic [2:0] probe_row;
    logic [2:0] probe_col;
    logic       cell_empty;
    logic       cell_p1;
    logic       cell_p2;
    logic       busy;
    logic       done;
    logic       win;
    logic [1:0] win_dir;

    win_checker dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .last_row   (last_row),
        .last_col   (last_col),
        .player     (player),
        .probe_row  (probe_row),
        .probe_col  (probe_col),
        .cell_empty (cell_empty),
        .cell_p1    (cell_p1),
        .cell_p2    (cell_p2),
        .busy       (busy),
        .done       (done),
        .win        (win),
        .win_dir    (win_dir)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int done_cnt = 0;
    int base_done = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         t0;
        int         lat;
        logic       w;
        logic [1:0] d;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    logic [5:0] plog[$];

    // Board model: 0 empty, 1 player1, 2 player2
    logic [1:0] board [0:5][0:6];

    always_comb begin
        cell_empty = 1'b1;
        cell_p1    = 1'b0;
        cell_p2    = 1'b0;
        if (probe_row <= 3'd5 && probe_col <= 3'd6) begin
            cell_empty = (board[probe_row][probe_col] == 2'd0);
            cell_p1    = (board[probe_row][probe_col] == 2'd1);
            cell_p2    = (board[probe_row][probe_col] == 2'd2);
        end
    end

    // Monitor: log probes while busy, pop the scoreboard on every done pulse
    always @(negedge clk) begin
        if (!reset && busy) begin
            plog.push_back({probe_row, probe_col});
            checks++;
            if (probe_row > 3'd5 || probe_col > 3'd6) begin
                errors++;
                $display("FAIL probe_range: got (%0d,%0d) need row<=5 col<=6", probe_row, probe_col);
            end
        end
        if (done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done at cycle %0d, required none", cyc);
            end else begin
                e = sb.pop_front();
                checks += 3;
                if (win !== e.w) begin
                    errors++;
                    $display("FAIL win: got %0b required %0b", win, e.w);
                end
                if (win_dir !== e.d) begin
                    errors++;
                    $display("FAIL win_dir: got %0d required %0d", win_dir, e.d);
                end
                if ((cyc - e.t0) != e.lat) begin
                    errors++;
                    $display("FAIL latency: got %0d required %0d", cyc - e.t0, e.lat);
                end
            end
        end
    end

    task automatic clear_board();
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 7; c++)
                board[r][c] = 2'd0;
    endtask

    task automatic put(input int r, input int c, input logic [1:0] v);
        board[r][c] = v;
    endtask

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, got, want);
        end
    endtask

    task automatic issue(input logic [2:0] r, input logic [2:0] c, input logic p,
                         input int lat, input logic w, input logic [1:0] d);
        exp_t x;
        @(negedge clk);
        last_row  = r;
        last_col  = c;
        player    = p;
        start     = 1'b1;
        base_done = done_cnt;
        plog.delete();
        x.t0 = cyc; x.lat = lat; x.w = w; x.d = d;
        sb.push_back(x);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen = 0;
        for (int i = 0; i < budget; i++) begin
            if (done_cnt != base_done) begin
                seen = 1;
                break;
            end
            @(negedge clk);
            #1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done within %0d cycles, required one", budget);
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] hexp [4];
        reset    = 1'b1;
        start    = 1'b0;
        last_row = 3'd0;
        last_col = 3'd0;
        player   = 1'b0;
        clear_board();
        #1;
        check("reset_busy",  busy,      0);
        check("reset_done",  done,      0);
        check("reset_win",   win,       0);
        check("reset_dir",   win_dir,   0);
        check("reset_probe", {probe_row, probe_col}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Horizontal win for player1 along the bottom row
        put(5,0,1); put(5,1,1); put(5,2,1); put(5,3,1);
        issue(3'd5, 3'd3, 1'b0, 5, 1'b1, 2'd0);
        wait_done(30);
        hexp[0] = {3'd5, 3'd4}; hexp[1] = {3'd5, 3'd2};
        hexp[2] = {3'd5, 3'd1}; hexp[3] = {3'd5, 3'd0};
        check("horiz_probe_count", (plog.size() >= 4) ? 1 : 0, 1);
        for (int i = 0; i < 4 && i < plog.size(); i++)
            check($sformatf("horiz_probe%0d", i), plog[i], hexp[i]);
        repeat (3) @(negedge clk);
        check("win_held",     win,     1);
        check("win_dir_held", win_dir, 0);

        // Same board, wrong player: no match anywhere
        issue(3'd5, 3'd3, 1'b1, 9, 1'b0, 2'd0);
        wait_done(30);

        // Vertical win on the right edge for player2
        clear_board();
        put(2,6,2); put(3,6,2); put(4,6,2); put(5,6,2);
        issue(3'd2, 3'd6, 1'b1, 6, 1'b1, 2'd1);
        wait_done(30);
        check("vert_oob_probe_zero", (plog.size() > 0) ? plog[0] : 6'h3f, 0);

        // Lone piece in the corner
        clear_board();
        put(0,0,1);
        issue(3'd0, 3'd0, 1'b0, 9, 1'b0, 2'd0);
        wait_done(30);

        // Broken run: opponent piece interrupts the row
        clear_board();
        put(5,0,1); put(5,1,2); put(5,2,1); put(5,3,1);
        issue(3'd5, 3'd3, 1'b0, 10, 1'b0, 2'd0);
        wait_done(30);

        // Diagonal win for player1
        clear_board();
        put(2,1,1); put(3,2,1); put(4,3,1); put(5,4,1);
        issue(3'd2, 3'd1, 1'b0, 8, 1'b1, 2'd2);
        wait_done(30);

        // Anti-diagonal win from the middle, needs both sides
        clear_board();
        put(2,4,2); put(3,3,2); put(4,2,2); put(5,1,2);
        issue(3'd3, 3'd3, 1'b1, 11, 1'b1, 2'd3);
        wait_done(30);

        // Out-of-range column: immediate finish, no win
        issue(3'd0, 3'd7, 1'b0, 1, 1'b0, 2'd0);
        wait_done(10);
        // Out-of-range row
        issue(3'd6, 3'd0, 1'b1, 1, 1'b0, 2'd0);
        wait_done(10);

        // Start repeated while busy is ignored: exactly one done
        clear_board();
        put(5,0,1); put(5,1,1); put(5,2,1); put(5,3,1);
        issue(3'd5, 3'd3, 1'b0, 5, 1'b1, 2'd0);
        last_col = 3'd7;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        wait_done(30);
        repeat (10) @(negedge clk);
        #1;
        check("single_done", done_cnt - base_done, 1);

        // Reset three cycles into a scan
        clear_board();
        put(5,0,1); put(5,1,2); put(5,2,1); put(5,3,1);
        issue(3'd5, 3'd3, 1'b0, 10, 1'b0, 2'd0);
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("mid_reset_busy",  busy, 0);
        check("mid_reset_done",  done, 0);
        check("mid_reset_win",   win,  0);
        check("mid_reset_probe", {probe_row, probe_col}, 0);
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        #1;
        check("no_done_after_reset", done_cnt - base_done, 0);

        // First start after reset is accepted normally
        clear_board();
        put(5,0,1); put(5,1,1); put(5,2,1); put(5,3,1);
        issue(3'd5, 3'd3, 1'b0, 5, 1'b1, 2'd0);
        wait_done(30);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/win_checker.md
WIN_CHECKER -- requirements
Module: win_checker

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  async active-high reset.
REQ-004 start  in  1  one-cycle request to check the move just placed.
REQ-005 last_row  in  3  row of placed piece, valid 0..5, sampled on accepted start.
REQ-006 last_col  in  3  column of placed piece, valid 0..6, sampled on accepted start.
REQ-007 player  in  1  mover; 0 = player1, 1 = player2; sampled on accepted start.
REQ-008 probe_row  out  3  row presented to the cell-state checker.
REQ-009 probe_col  out  3  column presented to the cell-state checker.
REQ-010 cell_empty, cell_p1, cell_p2  in  1 each  same-cycle combinational cell-state response for (probe_row, probe_col).
REQ-011 busy  out  1  high from the cycle after an accepted start until done.
REQ-012 done  out  1  one-cycle pulse at end of check.
REQ-013 win  out  1  result; held from done until the next accepted start.
REQ-014 win_dir  out  2  winning direction: 0 horizontal (0,+1), 1 vertical (+1,0), 2 diagonal (+1,+1), 3 anti-diagonal (+1,-1); held with win.

Function
REQ-015 SHALL have states IDLE, SCAN, FIN.
REQ-016 start SHALL be accepted only in IDLE; start in SCAN/FIN SHALL be ignored.
REQ-017 Accepted start with last_row>5 or last_col>6 SHALL go to FIN; done one cycle later with win=0, win_dir=0.
REQ-018 Valid start SHALL latch inputs, clear win/win_dir, and set dir=0, side=+, step=1, count=1; the placed cell SHALL never be probed.
REQ-019 In SCAN, candidate = last + step*sign(side)*delta(dir), computed at least 4 bits signed; in-bounds means row 0..5 and col 0..6.
REQ-020 probe_row/probe_col SHALL equal the candidate when it is in bounds, else 0.
REQ-021 Match means (player=0 and cell_p1) or (player=1 and cell_p2).
REQ-022 Each SCAN cycle: in bounds and match -> count+1, step+1; otherwise the side ends.
REQ-023 A side SHALL also end after the step-3 match.
REQ-024 When count reaches 4, go to FIN next cycle with win=1 and win_dir=dir; scanning stops.
REQ-025 Side end: step=1; after side + go to side -; after side - reset count=1 and advance dir.
REQ-026 If the side - of dir 3 ends, go to FIN with win=0.
REQ-027 Each SCAN cycle SHALL consume exactly one probe or one side end; SCAN SHALL last at most 24 cycles.
REQ-028 FIN: done=1 for one cycle, busy=0, next state IDLE.
REQ-029 busy SHALL be high in SCAN and low in IDLE/FIN.
REQ-030 Cell states are sampled only in SCAN; board changes during SCAN are not masked.

Reset
REQ-031 reset SHALL force IDLE immediately, including mid-scan, with busy=0, done=0, win=0, win_dir=0, probe_row=0, probe_col=0, and all internal counters 0.
REQ-032 The first start after reset deassertion SHALL be accepted normally.

Verification
REQ-033 Horizontal win: player1 at (5,0),(5,1),(5,2),(5,3); start with last=(5,3), player=0 -> probes (5,4), (5,2), (5,1), (5,0); done 5 cycles after start, win=1, win_dir=0.
REQ-034 Vertical edge: player2 at rows 2..5, col 6; last=(2,6) -> row-1 probe skipped as out of bounds; win=1, win_dir=1.
REQ-035 Lone piece at (0,0) on empty board -> no out-of-range probe address; done within 25 cycles; win=0.
REQ-036 Broken run: player1 at (5,0),(5,2),(5,3), player2 at (5,1), last=(5,3) -> horizontal count stops at 2; win=0.
REQ-037 Reset asserted 3 cycles into SCAN -> same cycle busy=0, probes 0, no done pulse.
REQ-038 Robustness: start repeated while busy -> ignored, single done; start with last_col=7 -> done after 1 cycle, win=0.
